// File: rtl/wb_master_pkg.sv
// Shared definitions for the Wishbone pipelined bus master: FSM state
// encoding and the read-data value returned on an error or timeout.
package wb_master_pkg;

  // FSM state encoding (kept as plain 2-bit constants for legacy tools)
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REQUEST  = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK = 2'd2;

  // Read data reported when a transaction ends in error or timeout
  localparam logic [31:0] ERROR_READ_DATA = 32'hFFFFFFFF;

  // True while a bus cycle is open (REQUEST or WAIT_ACK)
  function automatic logic state_active(input logic [1:0] st);
    return (st == ST_REQUEST) || (st == ST_WAIT_ACK);
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Bounded cycle counter for the bus master. It is held at zero while
// clear is high and counts every enabled cycle. expired marks the last
// cycle before the count would reach TERMINAL_COUNT, so the owner can act
// on the same edge the count reaches it. TERMINAL_COUNT = 0 disables it.
module wb_timeout_counter #(
  parameter int TERMINAL_COUNT = 255,
  parameter int COUNT_BITS     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [COUNT_BITS-1:0] LAST_COUNT = COUNT_BITS'(TERMINAL_COUNT - 1);

  logic [COUNT_BITS-1:0] count;

  // Count enabled cycles; synchronous reset and clear both zero the count
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (TERMINAL_COUNT != 0) && enable && (count == LAST_COUNT);

endmodule

// File: rtl/wb_peripheral_bus_master.sv
// Wishbone pipelined initiator. Each accepted local request becomes one
// Wishbone transaction; the completion pulse returns read data and status.
//
// Handshakes: on the local side master_request is a one-cycle valid and
// !master_busy is ready; a request seen while busy is dropped, not queued.
// On the bus side the strobe is accepted by the slave in the first cycle
// stb=1 and stall=0; ack or error ends the cycle (error wins if both), and
// either one is honoured even while the strobe is still stalled.
module wb_peripheral_bus_master
  import wb_master_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 24,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_BITS   = 8
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     master_request,
  input  logic                     master_we,
  input  logic [ADDRESS_WIDTH-1:0] master_address,
  input  logic [3:0]               master_byteSelect,
  input  logic [31:0]              master_dataWrite,
  output logic                     master_busy,
  output logic                     master_done,
  output logic                     master_error,
  output logic                     master_timeout,
  output logic [31:0]              master_dataRead,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  output logic                     wb_we_o,
  output logic [3:0]               wb_sel_o,
  output logic [ADDRESS_WIDTH-1:0] wb_adr_o,
  output logic [31:0]              wb_data_o,
  input  logic                     wb_ack_i,
  input  logic                     wb_stall_i,
  input  logic                     wb_error_i,
  input  logic [31:0]              wb_data_i
);

  logic [1:0] state;
  logic       timer_expired;
  logic       response;

  assign response = wb_ack_i | wb_error_i;

  // Timeout counter runs only while a bus cycle is open and restarts from
  // zero for every transaction because it is held clear in IDLE.
  wb_timeout_counter #(
    .TERMINAL_COUNT(TIMEOUT_CYCLES),
    .COUNT_BITS    (TIMEOUT_BITS)
  ) u_timeout (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .clear  (state == ST_IDLE),
    .enable (state_active(state)),
    .expired(timer_expired)
  );

  // Transaction FSM; every output is a register updated here
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state           <= ST_IDLE;
      wb_cyc_o        <= 1'b0;
      wb_stb_o        <= 1'b0;
      wb_we_o         <= 1'b0;
      wb_sel_o        <= '0;
      wb_adr_o        <= '0;
      wb_data_o       <= '0;
      master_busy     <= 1'b0;
      master_done     <= 1'b0;
      master_error    <= 1'b0;
      master_timeout  <= 1'b0;
      master_dataRead <= ERROR_READ_DATA;
    end else begin
      // Status flags are pulses that accompany master_done
      master_done    <= 1'b0;
      master_error   <= 1'b0;
      master_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (master_request) begin
            wb_we_o     <= master_we;
            wb_adr_o    <= master_address;
            wb_sel_o    <= master_byteSelect;
            wb_data_o   <= master_dataWrite;
            wb_cyc_o    <= 1'b1;
            wb_stb_o    <= 1'b1;
            master_busy <= 1'b1;
            state       <= ST_REQUEST;
          end
        end
        ST_REQUEST, ST_WAIT_ACK: begin
          if (response || timer_expired) begin
            // Completion: a real response beats a timeout in the same cycle
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            master_busy <= 1'b0;
            master_done <= 1'b1;
            state       <= ST_IDLE;
            if (!response) begin
              master_timeout <= 1'b1;
            end
            if (wb_error_i || !response) begin
              master_error    <= 1'b1;
              master_dataRead <= ERROR_READ_DATA;
            end else if (!wb_we_o) begin
              master_dataRead <= wb_data_i;
            end
          end else if ((state == ST_REQUEST) && !wb_stall_i) begin
            // Strobe accepted: drop it, keep the cycle open for the ack
            wb_stb_o <= 1'b0;
            state    <= ST_WAIT_ACK;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
